// File: rtl/adder_sweep_checker.sv
// Exhaustive operand sweeper and checker for a combinational adder. Each vector is held SETTLE_CYCLES, then checked in one cycle.
// No backpressure: the sweep runs free once started, and start is ignored while busy.
module adder_sweep_checker #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_op_a,
    output logic [WIDTH-1:0] o_op_b,
    input  logic [WIDTH:0]   i_sum_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [15:0]      o_err_count,
    output logic             o_first_err_valid,
    output logic [WIDTH-1:0] o_first_err_a,
    output logic [WIDTH-1:0] o_first_err_b
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_settle_cnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [15:0]      r_err_count;
    logic             r_first_vld;
    logic [WIDTH-1:0] r_first_a;
    logic [WIDTH-1:0] r_first_b;

    logic [WIDTH:0]   w_golden;
    logic             w_mismatch;
    logic             w_last_vec;
    logic             w_launch;

    // Full-width golden sum: the carry-out bit is compared too.
    assign w_golden   = {1'b0, r_op_a} + {1'b0, r_op_b};
    assign w_mismatch = (i_sum_in != w_golden);
    assign w_last_vec = (r_op_a == '1) && (r_op_b == '1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_launch     = 1'b1;
                    w_next_state = S_DRIVE;
                end
            end
            S_DRIVE: begin
                o_busy = 1'b1;
                if (r_settle_cnt == LAST_SETTLE) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                o_busy       = 1'b1;
                w_next_state = w_last_vec ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_launch     = 1'b1;
                    w_next_state = S_DRIVE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_settle_cnt <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_err_count  <= '0;
            r_first_vld  <= 1'b0;
            r_first_a    <= '0;
            r_first_b    <= '0;
        end else if (w_launch) begin
            r_settle_cnt <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_err_count  <= '0;
            r_first_vld  <= 1'b0;
            r_first_a    <= '0;
            r_first_b    <= '0;
        end else if (r_state == S_DRIVE) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end else if (r_state == S_CHECK) begin
            r_settle_cnt <= '0;
            if (w_mismatch) begin
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                if (!r_first_vld) begin
                    r_first_vld <= 1'b1;
                    r_first_a   <= r_op_a;
                    r_first_b   <= r_op_b;
                end
            end
            // A is the inner loop; operands stay at max once the sweep ends.
            if (!w_last_vec) begin
                if (r_op_a == '1) begin
                    r_op_a <= '0;
                    r_op_b <= r_op_b + 1'b1;
                end else begin
                    r_op_a <= r_op_a + 1'b1;
                end
            end
        end
    end

    assign o_op_a            = r_op_a;
    assign o_op_b            = r_op_b;
    assign o_pass            = (r_state == S_DONE) && (r_err_count == 16'd0);
    assign o_err_count       = r_err_count;
    assign o_first_err_valid = r_first_vld;
    assign o_first_err_a     = r_first_a;
    assign o_first_err_b     = r_first_b;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker at WIDTH=4, SETTLE_CYCLES=3 with a faultable adder model.
module tb_adder_sweep_checker;

    localparam int W       = 4;
    localparam int S       = 3;
    localparam int SWEEP   = (1 << (2 * W)) * (S + 1);
    localparam int TIMEOUT = SWEEP + 100;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W:0]   sum_in;
    logic         busy;
    logic         done;
    logic         pass;
    logic [15:0]  err_count;
    logic         first_err_valid;
    logic [W-1:0] first_err_a;
    logic [W-1:0] first_err_b;

    int fault_mode;
    int n_cmp;
    int n_bad;

    adder_sweep_checker #(
        .WIDTH        (W),
        .SETTLE_CYCLES(S)
    ) u_dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .o_op_a           (op_a),
        .o_op_b           (op_b),
        .i_sum_in         (sum_in),
        .o_busy           (busy),
        .o_done           (done),
        .o_pass           (pass),
        .o_err_count      (err_count),
        .o_first_err_valid(first_err_valid),
        .o_first_err_a    (first_err_a),
        .o_first_err_b    (first_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder under test, with injectable faults.
    always_comb begin
        sum_in = {1'b0, op_a} + {1'b0, op_b};
        case (fault_mode)
            1: sum_in[W] = 1'b0;
            2: sum_in = {1'b0, op_a} + {1'b0, op_b} + 5'd1;
            3: sum_in[0] = 1'b0;
            4: if (op_a == 4'd5 && op_b == 4'd9) sum_in = sum_in ^ 5'd1;
            5: if (op_b == 4'hF) sum_in = sum_in ^ 5'd1;
            default: ;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " op_a"}, int'(op_a), 0);
        chk({tag, " op_b"}, int'(op_b), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " pass"}, int'(pass), 0);
        chk({tag, " err_count"}, int'(err_count), 0);
        chk({tag, " first_err_valid"}, int'(first_err_valid), 0);
        chk({tag, " first_err_a"}, int'(first_err_a), 0);
        chk({tag, " first_err_b"}, int'(first_err_b), 0);
    endtask

    // Pulses start and follows the sweep to done. lat = edges from the start edge to done.
    // Optionally pulses start again mid-sweep; counts operand hold runs that are not S+1 long.
    task automatic run_sweep(input int repulse_at, output int lat, output int hold_bad);
        int           cyc;
        int           run;
        logic [W-1:0] prev_a;
        start    = 1'b1;
        cyc      = 0;
        run      = 0;
        hold_bad = 0;
        prev_a   = '0;
        lat      = -1;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == repulse_at);
            if (cyc == 1) begin
                chk("busy after start", int'(busy), 1);
                chk("done after start", int'(done), 0);
                chk("err cleared on start", int'(err_count), 0);
                chk("first_err cleared on start", int'(first_err_valid), 0);
                run    = 1;
                prev_a = op_a;
            end else if (busy) begin
                if (op_a != prev_a) begin
                    if (run != S + 1) hold_bad++;
                    run = 1;
                end else begin
                    run++;
                end
                prev_a = op_a;
            end
        end while (!done && cyc < TIMEOUT);
        start = 1'b0;
        if (done) lat = cyc - 1;
    endtask

    typedef struct {
        int          mode;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic        exp_fv;
        logic [W-1:0] exp_fa;
        logic [W-1:0] exp_fb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int hold_bad;
        n_cmp      = 0;
        n_bad      = 0;
        fault_mode = 0;
        reset      = 1'b1;
        start      = 1'b0;

        vecs[0] = '{0, 1'b1, 16'd0,   1'b0, 4'h0, 4'h0};  // ideal adder
        vecs[1] = '{1, 1'b0, 16'd120, 1'b1, 4'hF, 4'h1};  // carry-out stuck at 0
        vecs[2] = '{2, 1'b0, 16'd256, 1'b1, 4'h0, 4'h0};  // A+B+1: every vector fails
        vecs[3] = '{3, 1'b0, 16'd128, 1'b1, 4'h1, 4'h0};  // LSB stuck at 0
        vecs[4] = '{4, 1'b0, 16'd1,   1'b1, 4'h5, 4'h9};  // single bad vector
        vecs[5] = '{5, 1'b0, 16'd16,  1'b1, 4'h0, 4'hF};  // bad whenever B is max

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            fault_mode = vecs[i].mode;
            run_sweep(0, lat, hold_bad);
            chk($sformatf("v%0d latency", i), lat, SWEEP);
            chk($sformatf("v%0d hold", i), hold_bad, 0);
            chk($sformatf("v%0d busy", i), int'(busy), 0);
            chk($sformatf("v%0d pass", i), int'(pass), int'(vecs[i].exp_pass));
            chk($sformatf("v%0d err_count", i), int'(err_count), int'(vecs[i].exp_err));
            chk($sformatf("v%0d first_vld", i), int'(first_err_valid), int'(vecs[i].exp_fv));
            chk($sformatf("v%0d first_a", i), int'(first_err_a), int'(vecs[i].exp_fa));
            chk($sformatf("v%0d first_b", i), int'(first_err_b), int'(vecs[i].exp_fb));
            chk($sformatf("v%0d op_a max", i), int'(op_a), 15);
            chk($sformatf("v%0d op_b max", i), int'(op_b), 15);
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d done holds", i), int'(done), 1);
            chk($sformatf("v%0d err holds", i), int'(err_count), int'(vecs[i].exp_err));
        end

        // Restart from DONE after a failing run: results clear, done drops one edge later.
        fault_mode = 0;
        run_sweep(0, lat, hold_bad);
        chk("restart latency", lat, SWEEP);
        chk("restart pass", int'(pass), 1);
        chk("restart err_count", int'(err_count), 0);

        // start during busy is ignored; sweep ends on the original schedule.
        run_sweep(300, lat, hold_bad);
        chk("ignored start latency", lat, SWEEP);
        chk("ignored start hold", hold_bad, 0);
        chk("ignored start pass", int'(pass), 1);

        // Reset mid-sweep, then a fresh full golden sweep.
        fault_mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        chk("pre-reset busy", int'(busy), 1);
        chk("pre-reset errors seen", int'(err_count != 0), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("mid reset");
        @(negedge clk);
        chk("post-reset idle busy", int'(busy), 0);
        fault_mode = 0;
        run_sweep(0, lat, hold_bad);
        chk("post-reset latency", lat, SWEEP);
        chk("post-reset pass", int'(pass), 1);
        chk("post-reset first_vld", int'(first_err_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Self-checking exhaustive stimulus stage that sits directly upstream of the combinational ripple-carry adder and consumes its result. On `start`, it sweeps every operand pair (A inner loop, B outer loop) and holds each pair stable for a settle window. It then samples the adder's sum and compares it against an internal golden `A+B`. It reports pass/fail, a saturating mismatch count and the first failing vector.

## Interface
- `WIDTH`, 8, operand width; the sum is `WIDTH+1` bits.
- `SETTLE_CYCLES`, 1, cycles operands are held before the sum is sampled; legal range ≥1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state and outputs.
- `start`  in  1  starts a sweep; sampled in IDLE or DONE only.
- `op_a`  out  WIDTH  operand A to the adder.
- `op_b`  out  WIDTH  operand B to the adder.
- `sum_in`  in  WIDTH+1  adder result for `op_a`/`op_b`.
- `busy`  out  1  high in DRIVE/CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_count==0`; 0 otherwise.
- `err_count`  out  16  mismatches this sweep; saturates at 16'hFFFF.
- `first_err_valid`  out  1  a mismatch has been captured this sweep.
- `first_err_a`, `first_err_b`  out  WIDTH each  operands of the first mismatch.

## Operation
- **Reset:** state IDLE; every output is 0, including the operands, counters, flags and first-error registers.
- **IDLE:** `start`=1 → DRIVE. `op_a`=`op_b`=0, `err_count`=0, `first_err_*`=0, settle counter=0.
- **DRIVE:** `op_a` and `op_b` are stable. The settle counter increments each cycle; after `SETTLE_CYCLES` cycles in DRIVE → CHECK.
- **CHECK (1 cycle):** compare `sum_in` with the golden sum `{1'b0,op_a}+{1'b0,op_b}` (WIDTH+1 bits, no truncation).
  - On mismatch:
    - `err_count` increments unless it is already 16'hFFFF.
    - If `first_err_valid`=0, capture `op_a`/`op_b` and set `first_err_valid`.
  - Advance the vector:
    - If `op_a`==max and `op_b`==max → DONE, with the operands left at max.
    - Else if `op_a`==max: `op_a`←0, `op_b`←`op_b`+1 → DRIVE.
    - Else `op_a`←`op_a`+1 → DRIVE.
- **DONE:** `done`=1 and `pass`=(`err_count`==0). Results hold until `start` or `reset`. `start`=1 → DRIVE with the same clears as from IDLE.
- **`start` in DRIVE/CHECK:** ignored; the sweep continues unaffected.
- **Reset mid-sweep:** takes priority over everything; the next state is IDLE with all outputs 0.
- **Sum check:** no bit of `sum_in` is masked; the carry-out bit (MSB) is checked.

## Timing
- `start` sampled at edge k → `busy`=1 and operands 0 are visible after edge k.
- Each vector occupies exactly `SETTLE_CYCLES`+1 cycles. Operands change only on the edge that ends CHECK.
- `sum_in` is sampled at the edge that ends CHECK, so its combinational path has `SETTLE_CYCLES`+1 cycles to settle.
- `done` rises at edge k + 2^(2·WIDTH)·(`SETTLE_CYCLES`+1). `busy` falls on the same edge.
- `err_count` and `first_err_*` update on the edge that ends the failing CHECK.
- `done`/`pass` fall one edge after a restart `start` is sampled.

## Test plan
- **Golden run:** WIDTH=8, S=1, ideal adder model; `start` pulsed for 1 cycle → `done` rises 131072 cycles later, with `pass`=1, `err_count`=0 and `first_err_valid`=0.
- **Carry-out stuck at 0:** `sum_in[8]` tied 0 → `err_count`=32640, `first_err_a`=8'hFF, `first_err_b`=8'h01, `pass`=0.
- **Saturation:** `sum_in`=A+B+1 → all 65536 vectors fail; `err_count`=16'hFFFF (saturated, not wrapped), first error at A=0, B=0.
- **Reset mid-sweep:** assert `reset` for 1 cycle at cycle 1000 → the next cycle shows all outputs 0 and `busy`=0. A new `start` runs a full golden sweep, finishing with `pass`=1.
- **`start` handling:**
  - Pulse `start` during `busy` → ignored; the sweep ends at the original time.
  - Pulse `start` in DONE after a failing run → `err_count` and `first_err_valid` clear and `done` drops one edge later.
- **Small config:** WIDTH=4, S=3 → `done` rises 1024 cycles after `start`. Each operand pair must be held for 4 cycles, checked by monitoring `op_a`.
